wall_placer: RTL

- Upstream stage of the wall renderer. On request, it generates up to four non-overlapping wall rectangles from a free-running LFSR.
- Publishes the positions (X1..X4, Y1..Y4), an orientation and an enable bit per wall, all atomically, so the renderer never sees a half-updated layout.
- Replaces the hard-coded wall coordinates currently fed to the renderer; a new layout is requested at each level start.

---
 rtl/wall_placer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wall_placer.sv
// Wall placer: builds up to four non-overlapping wall rectangles from a free-running LFSR
// and publishes them atomically. Define WALL_PLACER_FRAME_SYNC_EN to hold publication until a frame_clk rise.
`timescale 1ns/1ps
module wall_placer #(
  parameter logic [9:0]  X_Max      = 10'd639,
  parameter logic [9:0]  Y_Max      = 10'd479,
  parameter logic [9:0]  Wall_Long  = 10'd64,
  parameter logic [9:0]  Wall_Short = 10'd32,
  parameter logic [9:0]  Min_Gap    = 10'd8,
  parameter logic [4:0]  Max_Tries  = 5'd16,
  parameter logic [15:0] Seed       = 16'hACE1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [2:0] num_walls,
  output logic       busy,
  output logic       done,
  output logic [9:0] X1,
  output logic [9:0] X2,
  output logic [9:0] X3,
  output logic [9:0] X4,
  output logic [9:0] Y1,
  output logic [9:0] Y2,
  output logic [9:0] Y3,
  output logic [9:0] Y4,
  output logic [3:0] orient,
  output logic [3:0] wall_en
);

  typedef enum logic [2:0] {IDLE, GX, GY, CHK, COMMIT, PUBLISH} state_t;

  localparam logic [10:0] LONG  = {1'b0, Wall_Long};
  localparam logic [10:0] SHORT = {1'b0, Wall_Short};
  localparam logic [10:0] GAP   = {1'b0, Min_Gap};
  localparam logic [10:0] XLIM  = {1'b0, X_Max};
  localparam logic [10:0] YLIM  = {1'b0, Y_Max};
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic [2:0]      n_q, n_d, k_q, k_d;
  logic [4:0]      tries_q, tries_d;
  logic [1:0]      j_q, j_d;
  logic [9:0]      cx_q, cx_d, cy_q, cy_d;
  logic            co_q, co_d;
  logic [3:0][9:0] sx_q, sx_d, sy_q, sy_d;
  logic [3:0]      so_q, so_d, sen_q, sen_d;
  logic [3:0][9:0] px_q, px_d, py_q, py_d;
  logic [3:0]      po_q, po_d, pen_q, pen_d;
  logic            busy_q, busy_d, done_q, done_d;

  logic [10:0] cw, ch, cxe, cye, jx, jy, jw, jh;
  logic [2:0]  n_req, k_inc;
  logic        in_bounds, overlap, last_j, reject, give_up, more, pub_go;
  state_t      after_reject;

  assign n_req = (num_walls > 3'd4) ? 3'd4 : num_walls;
  assign k_inc = k_q + 3'd1;
  assign more  = (k_inc < n_q);

  // Candidate geometry; in GY the Y coordinate is taken straight from the LFSR
  assign cw  = co_q ? SHORT : LONG;
  assign ch  = co_q ? LONG : SHORT;
  assign cxe = {1'b0, cx_q};
  assign cye = {1'b0, cy_q};
  assign in_bounds = (cxe + cw <= XLIM) && ({1'b0, lfsr_q[9:0]} + ch <= YLIM);

  assign jx = {1'b0, sx_q[j_q]};
  assign jy = {1'b0, sy_q[j_q]};
  assign jw = so_q[j_q] ? SHORT : LONG;
  assign jh = so_q[j_q] ? LONG : SHORT;
  // Disabled slots never block a candidate
  assign overlap = sen_q[j_q] && (cxe <= jx + jw + GAP) && (jx <= cxe + cw + GAP) &&
                   (cye <= jy + jh + GAP) && (jy <= cye + ch + GAP);
  assign last_j  = ({1'b0, j_q} == k_q - 3'd1);

  assign reject       = ((state_q == GY) && !in_bounds) || ((state_q == CHK) && overlap);
  assign give_up      = (tries_q == Max_Tries - 5'd1);
  assign after_reject = (give_up && !more) ? PUBLISH : GX;

`ifdef WALL_PLACER_FRAME_SYNC_EN
  logic fs_q, fd_q, rise_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      fs_q   <= 1'b0;
      fd_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      fs_q   <= frame_clk;
      fd_q   <= fs_q;
      rise_q <= fs_q & ~fd_q;
    end
  end
  assign pub_go = rise_q;
`else
  logic unused_frame;
  assign unused_frame = frame_clk;
  assign pub_go = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      lfsr_q  <= Seed;
      n_q     <= '0;
      k_q     <= '0;
      tries_q <= '0;
      j_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      co_q    <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      so_q    <= '0;
      sen_q   <= '0;
      px_q    <= '0;
      py_q    <= '0;
      po_q    <= '0;
      pen_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      n_q     <= n_d;
      k_q     <= k_d;
      tries_q <= tries_d;
      j_q     <= j_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      co_q    <= co_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      so_q    <= so_d;
      sen_q   <= sen_d;
      px_q    <= px_d;
      py_q    <= py_d;
      po_q    <= po_d;
      pen_q   <= pen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (n_req == 3'd0) ? PUBLISH : GX;
      GX:      state_d = GY;
      GY:      if (!in_bounds) state_d = after_reject;
               else            state_d = (k_q != 3'd0) ? CHK : COMMIT;
      CHK:     if (overlap)     state_d = after_reject;
               else if (last_j) state_d = COMMIT;
      COMMIT:  state_d = more ? GX : PUBLISH;
      PUBLISH: if (pub_go) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
    n_d     = n_q;
    k_d     = k_q;
    tries_d = tries_q;
    j_d     = j_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    co_d    = co_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    so_d    = so_q;
    sen_d   = sen_q;
    px_d    = px_q;
    py_d    = py_q;
    po_d    = po_q;
    pen_d   = pen_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        // Clearing the shadow up front leaves slots >= n zero at publish
        n_d     = n_req;
        k_d     = 3'd0;
        tries_d = 5'd0;
        busy_d  = 1'b1;
        sx_d    = '0;
        sy_d    = '0;
        so_d    = '0;
        sen_d   = '0;
      end
      GX: begin
        cx_d = lfsr_q[9:0];
        co_d = lfsr_q[15];
      end
      GY: begin
        cy_d = lfsr_q[9:0];
        j_d  = 2'd0;
      end
      CHK: if (!overlap && !last_j) j_d = j_q + 2'd1;
      COMMIT: begin
        sx_d[k_q[1:0]]  = cx_q;
        sy_d[k_q[1:0]]  = cy_q;
        so_d[k_q[1:0]]  = co_q;
        sen_d[k_q[1:0]] = 1'b1;
        k_d     = k_inc;
        tries_d = 5'd0;
      end
      PUBLISH: if (pub_go) begin
        px_d   = sx_q;
        py_d   = sy_q;
        po_d   = so_q;
        pen_d  = sen_q;
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
    if (reject) begin
      if (give_up) begin
        sx_d[k_q[1:0]]  = '0;
        sy_d[k_q[1:0]]  = '0;
        so_d[k_q[1:0]]  = 1'b0;
        sen_d[k_q[1:0]] = 1'b0;
        k_d     = k_inc;
        tries_d = 5'd0;
      end else begin
        tries_d = tries_q + 5'd1;
      end
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign X1      = px_q[0];
  assign X2      = px_q[1];
  assign X3      = px_q[2];
  assign X4      = px_q[3];
  assign Y1      = py_q[0];
  assign Y2      = py_q[1];
  assign Y3      = py_q[2];
  assign Y4      = py_q[3];
  assign orient  = po_q;
  assign wall_en = pen_q;

endmodule
